// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset while idle, releases it on start, counts RUN cycles
// and stops on core_done. Define RUN_CTRL_WDOG_EN to enable the RUN-cycle watchdog (FAULT state).
module run_ctrl #(
   parameter int RST_CYCLES = 2,
   parameter int CW         = 16,
   parameter int MAX_CYCLES = 4000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          abort,
   input  logic          core_done,
   output logic          core_rst,
   output logic          busy,
   output logic          done,
   output logic          timeout,
   output logic [CW-1:0] cycles
);

   localparam int            RW        = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
   localparam logic [CW-1:0] CYC_LIMIT = CW'(MAX_CYCLES);

`ifdef RUN_CTRL_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESET,
      S_RUN,
      S_DONE,
      S_FAULT
   } state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic [CW-1:0] cycles_q, cycles_d;
   logic [CW-1:0] cycles_inc;
   logic          wdog_hit;
   logic          core_rst_q, core_rst_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef RUN_CTRL_WDOG_EN
   logic          timeout_q, timeout_d;
`endif

   // Outputs are computed from the next state so they change on the same edge as the state.
   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      cycles_d   = cycles_q;
      cycles_inc = (cycles_q == '1) ? cycles_q : cycles_q + CW'(1);
      wdog_hit   = WDOG_EN && (cycles_inc == CYC_LIMIT);

      case (state_q)
         S_IDLE, S_DONE, S_FAULT: begin
            if (start) begin
               state_d   = S_RESET;
               rst_cnt_d = '0;
               cycles_d  = '0;
            end
         end
         S_RESET: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (rst_cnt_q == RST_LAST) begin
               state_d = S_RUN;
            end else begin
               rst_cnt_d = rst_cnt_q + RW'(1);
            end
         end
         S_RUN: begin
            // The cycle in which completion or abort is seen still counts as a RUN cycle.
            cycles_d = cycles_inc;
            if (abort) begin
               state_d = S_IDLE;
            end else if (core_done) begin
               state_d = S_DONE;
            end else if (wdog_hit) begin
               state_d = S_FAULT;
            end
         end
         default: state_d = S_IDLE;
      endcase

      core_rst_d = (state_d != S_RUN);
      busy_d     = (state_d == S_RESET) || (state_d == S_RUN);
      done_d     = (state_d == S_DONE);
`ifdef RUN_CTRL_WDOG_EN
      timeout_d  = (state_d == S_FAULT);
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rst_cnt_q  <= '0;
         cycles_q   <= '0;
         core_rst_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef RUN_CTRL_WDOG_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         cycles_q   <= cycles_d;
         core_rst_q <= core_rst_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
`ifdef RUN_CTRL_WDOG_EN
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign core_rst = core_rst_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign cycles   = cycles_q;
`ifdef RUN_CTRL_WDOG_EN
   assign timeout  = timeout_q;
`else
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Testbench for run_ctrl: table of directed vectors plus hand-written multi-cycle sequences.
// Watchdog sequences follow RUN_CTRL_WDOG_EN; the default build checks that no timeout occurs.
module tb_run_ctrl;

   localparam int CW = 16;

   // Flag encodings: stimulus {reset, start, abort, core_done}; expected {core_rst, busy, done, timeout}
   localparam logic [3:0] F_IDLE  = 4'b1000;
   localparam logic [3:0] F_RESET = 4'b1100;
   localparam logic [3:0] F_RUN   = 4'b0100;
   localparam logic [3:0] F_DONE  = 4'b1010;
   localparam logic [3:0] F_FAULT = 4'b1001;

   logic          clk       = 1'b0;
   logic          reset     = 1'b0;
   logic          start     = 1'b0;
   logic          abort     = 1'b0;
   logic          core_done = 1'b0;
   logic          core_rst;
   logic          busy;
   logic          done;
   logic          timeout;
   logic [CW-1:0] cycles;

   int checks   = 0;
   int failures = 0;

   run_ctrl #(
      .RST_CYCLES(2),
      .CW        (CW),
      .MAX_CYCLES(20)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .core_done(core_done),
      .core_rst (core_rst),
      .busy     (busy),
      .done     (done),
      .timeout  (timeout),
      .cycles   (cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [3:0]    stim;
      logic [3:0]    exp_flags;
      logic [CW-1:0] exp_cycles;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input string name, input logic [3:0] stim,
                                   input logic [3:0] exp_flags, input int exp_cycles);
      vec_t v;
      v.name       = name;
      v.stim       = stim;
      v.exp_flags  = exp_flags;
      v.exp_cycles = CW'(exp_cycles);
      vecs.push_back(v);
   endfunction

   // Drive inputs, let one rising edge pass, and settle away from the edge.
   task automatic applyStimulus(input logic [3:0] stim);
      {reset, start, abort, core_done} = stim;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] exp_flags,
                              input logic [CW-1:0] exp_cycles);
      checks++;
      if ({core_rst, busy, done, timeout} !== exp_flags || cycles !== exp_cycles) begin
         failures++;
         $display("[TB] FAIL %s: got core_rst/busy/done/timeout=%b cycles=%0d, want %b cycles=%0d",
                  name, {core_rst, busy, done, timeout}, cycles, exp_flags, exp_cycles);
      end
   endtask

   task automatic step_check(input string name, input logic [3:0] stim,
                             input logic [3:0] exp_flags, input int exp_cycles);
      applyStimulus(stim);
      checkOutput(name, exp_flags, CW'(exp_cycles));
   endtask

   // Start a run and step through the two RESET cycles into the first RUN cycle.
   task automatic enter_run(input string tag);
      step_check({tag, "_start"}, 4'b1100, F_RESET, 0);
      step_check({tag, "_reset"}, 4'b1000, F_RESET, 0);
      step_check({tag, "_run0"},  4'b1000, F_RUN,   0);
   endtask

   task automatic idle_run(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'b1000);
   endtask

   initial begin
      add_vec("reset0", 4'b0000, F_IDLE, 0);
      add_vec("reset1", 4'b0000, F_IDLE, 0);
      for (int i = 0; i < 5; i++) add_vec($sformatf("idle%0d", i), 4'b1000, F_IDLE, 0);

      // Normal run: core_done on the 10th RUN cycle; start during RUN is ignored.
      add_vec("run1_start", 4'b1100, F_RESET, 0);
      add_vec("run1_reset", 4'b1000, F_RESET, 0);
      add_vec("run1_rel",   4'b1000, F_RUN,   0);
      for (int i = 1; i <= 9; i++)
         add_vec($sformatf("run1_cyc%0d", i), (i == 5) ? 4'b1100 : 4'b1000, F_RUN, i);
      add_vec("run1_done",      4'b1001, F_DONE, 10);
      add_vec("done_stale",     4'b1001, F_DONE, 10);
      add_vec("done_abort_ign", 4'b1010, F_DONE, 10);

      // Rerun from DONE with completion after 4 RUN cycles.
      add_vec("run2_start", 4'b1100, F_RESET, 0);
      add_vec("run2_reset", 4'b1000, F_RESET, 0);
      add_vec("run2_rel",   4'b1000, F_RUN,   0);
      for (int i = 1; i <= 3; i++) add_vec($sformatf("run2_cyc%0d", i), 4'b1000, F_RUN, i);
      add_vec("run2_done",  4'b1001, F_DONE, 4);

      // Abort together with core_done on the 3rd RUN cycle: abort wins.
      add_vec("run3_start", 4'b1100, F_RESET, 0);
      add_vec("run3_reset", 4'b1000, F_RESET, 0);
      add_vec("run3_rel",   4'b1000, F_RUN,   0);
      add_vec("run3_cyc1",  4'b1000, F_RUN,   1);
      add_vec("run3_cyc2",  4'b1000, F_RUN,   2);
      add_vec("run3_abort", 4'b1011, F_IDLE,  3);
      add_vec("idle_done_ign",  4'b1001, F_IDLE, 3);
      add_vec("idle_abort_ign", 4'b1010, F_IDLE, 3);

      // Abort while the core is still held in RESET.
      add_vec("run4_start",       4'b1100, F_RESET, 0);
      add_vec("run4_abort_reset", 4'b1010, F_IDLE,  0);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].stim);
         checkOutput(vecs[i].name, vecs[i].exp_flags, vecs[i].exp_cycles);
      end

      // Reset mid-run on RUN cycle 5, then a done flag while idle.
      enter_run("mid");
      idle_run(4);
      checkOutput("mid_cyc4", F_RUN, CW'(4));
      step_check("mid_reset", 4'b0000, F_IDLE, 0);
      for (int i = 0; i < 3; i++) applyStimulus(4'b1001);
      checkOutput("mid_idle_done_ign", F_IDLE, CW'(0));

`ifdef RUN_CTRL_WDOG_EN
      // Watchdog expiry at 20 RUN cycles without completion.
      enter_run("wd");
      idle_run(19);
      checkOutput("wd_cyc19", F_RUN, CW'(19));
      step_check("wd_fault", 4'b1000, F_FAULT, 20);
      step_check("wd_hold",  4'b1001, F_FAULT, 20);
      step_check("wd_abort_ign", 4'b1010, F_FAULT, 20);
      // Completion on the expiry cycle wins over the watchdog.
      enter_run("wd2");
      idle_run(19);
      checkOutput("wd2_cyc19", F_RUN, CW'(19));
      step_check("wd2_done", 4'b1001, F_DONE, 20);
`else
      // Without the watchdog, RUN continues well past 20 cycles and timeout stays low.
      enter_run("nowd");
      idle_run(25);
      checkOutput("nowd_cyc25", F_RUN, CW'(25));
      step_check("nowd_done", 4'b1001, F_DONE, 26);
`endif

      step_check("final_reset", 4'b0000, F_IDLE, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run controller that sequences one program execution on the 9-bit-instruction core. It holds the core in reset while idle, releases it on a host start request, counts execution cycles, and detects completion from the core's `done` flag (PC == 255). It sits between the testbench/host and the core's `reset` input, and reports done/timeout status plus a cycle count.

## Interface
- `RST_CYCLES`, default 2: cycles `core_rst` is held high in RESET before release (≥1).
- `CW`, default 16: width of the cycle counter.
- `MAX_CYCLES`, default 4000: watchdog limit in RUN cycles (< 2^CW); used only with `RUN_CTRL_WDOG_EN`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  request a run; sampled in IDLE, DONE, FAULT.
- `abort`  in  1  cancel the current run; sampled in RESET, RUN.
- `core_done`  in  1  core completion flag; sampled only in RUN.
- `core_rst`  out  1  active-high reset to the core.
- `busy`  out  1  high in RESET and RUN.
- `done`  out  1  high in DONE.
- `timeout`  out  1  high in FAULT.
- `cycles`  out  CW  RUN cycles of the last or current run.

## Operation
- States: IDLE, RESET, RUN, DONE, FAULT; all outputs registered, derived from state plus counters.
- Reset (`reset`=0 at an edge): state IDLE, `core_rst`=1, `busy`=0, `done`=0, `timeout`=0, `cycles`=0, internal reset counter = 0. Reset dominates every other input and applies from any state, including mid-run.
- IDLE: `core_rst`=1. `start`=1 → RESET, clear `cycles` and the reset counter.
- RESET: `core_rst`=1, `busy`=1; reset counter increments each cycle. After RST_CYCLES cycles in RESET → RUN.
- RUN: `core_rst`=0, `busy`=1; `cycles` increments by 1 every RUN cycle, including the cycle `core_done` is seen, and saturates at 2^CW−1. `core_done`=1 → DONE.
- DONE: `core_rst`=1 (core frozen), `done`=1; `cycles` held. `start`=1 → RESET (clears `cycles`, `done` drops). Otherwise stays in DONE.
- FAULT: `core_rst`=1, `timeout`=1, `cycles` held. `start`=1 → RESET.
- `abort`=1 in RESET or RUN → IDLE; `cycles` held; `done`/`timeout` stay 0. `abort` is ignored in other states.
- Simultaneous events:
  - `abort` and `core_done` together in RUN: abort wins.
  - `core_done` and watchdog expiry in the same cycle: DONE wins.
  - `start` in RESET or RUN: ignored.
- `core_done` outside RUN is ignored. This covers a stale done from the previous run, which is masked while the core is held in reset.

## Timing
- `start` sampled at edge N in IDLE: RESET from N+1; RUN (`core_rst`=0) from N+RST_CYCLES+1.
- With defaults, the core sees `core_rst` deasserted 3 cycles after the start edge.
- `core_done` sampled high at RUN edge M: DONE, `done`=1, and `core_rst`=1 from M+1. `cycles` equals the number of RUN edges through M.
- Minimum run: `core_done` high on the first RUN cycle gives `cycles`=1.
- Worst-case latency to freeze the core after completion: 1 cycle.
- `busy` falls in the same cycle `done` or `timeout` rises.

## Configuration
- `RUN_CTRL_WDOG_EN` defined: in RUN, when `cycles` reaches `MAX_CYCLES` and `core_done`=0 at that edge → FAULT, `timeout`=1, `cycles`=MAX_CYCLES.
- `RUN_CTRL_WDOG_EN` undefined: no watchdog; FAULT is unreachable; `timeout` is tied to 0; RUN continues until `core_done`, `abort` or `reset`, with `cycles` saturating.

## Test plan
- Reset then idle: hold `reset`=0 for 2 cycles, release, no start for 5 cycles → `core_rst`=1, `busy`=0, `done`=0, `timeout`=0, `cycles`=0 throughout.
- Normal run (defaults): pulse `start`, raise `core_done` on the 10th RUN cycle → `core_rst` low exactly 3 cycles after start; `done`=1 next cycle; `cycles`=10; `core_rst`=1.
- Rerun from DONE: `start` in DONE → `done` drops, `cycles`=0 next cycle; second run with `core_done` after 4 RUN cycles → `cycles`=4.
- Abort: `start`, then `abort`=1 together with `core_done`=1 on the 3rd RUN cycle → IDLE, `done`=0, `cycles`=3.
- Watchdog (`RUN_CTRL_WDOG_EN`, `MAX_CYCLES`=20): never assert `core_done` → `timeout`=1, `cycles`=20, `core_rst`=1. Variant with `core_done` on RUN cycle 20 → `done`=1, `timeout`=0.
- Reset mid-run: `reset`=0 on RUN cycle 5 → next cycle IDLE, `cycles`=0, `core_rst`=1; `core_done`=1 while IDLE is ignored.
